impulse_counter_n: RTL

IMPULSE_COUNTER_N -- requirements
Module: impulse_counter_n

---
 rtl/impulse_counter_pkg.sv | 15 +
 rtl/sync_edge_det.sv | 35 +++
 rtl/impulse_counter_n.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/impulse_counter_pkg.sv
// Shared definitions for the multi-channel impulse counter: default parameters
// and the readout FSM state encoding.
package impulse_counter_pkg;

    localparam int NCH_DEFAULT = 8;
    localparam int CW_DEFAULT  = 8;
    localparam int SAT_DEFAULT = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge detector; emits a one-cycle
// pulse in the clk domain for every rising edge seen on the async input.
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic pulse_d;

    // Synchronizer chain plus one-cycle history for the edge detector
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    // Pulse is decoded from flops only, so it is glitch-free in the clk domain
    always_comb begin
        pulse_d = sync_q & ~prev_q;
    end

    assign pulse = pulse_d;

endmodule

// File: rtl/impulse_counter_n.sv
// NCH-channel impulse counter: counts rising edges per channel over windows
// closed by rtc, then streams the frozen window out serially, MSB first.
module impulse_counter_n
    import impulse_counter_pkg::*;
#(
    parameter int NCH = NCH_DEFAULT,
    parameter int CW  = CW_DEFAULT,
    parameter int SAT = SAT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH-1:0]          ch,
    input  logic                    rtc,
    output logic                    serial_out,
    output logic [$clog2(NCH)-1:0]  addr,
    output logic                    sl,
    output logic                    busy,
    output logic                    ovf_global,
    output logic                    ovf_rtc
);

    localparam int AW = $clog2(NCH);
    localparam int BW = $clog2(CW);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(NCH - 1);
    localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CW - 1);

    logic [NCH-1:0] ch_pulse_s;
    logic           rtc_pulse_s;
    logic           snap_s;
    logic [CW-1:0]  word_s;

    logic [CW-1:0]  cnt_q    [NCH];
    logic [CW-1:0]  cnt_d    [NCH];
    logic [CW-1:0]  shadow_q [NCH];
    logic [CW-1:0]  shadow_d [NCH];
    logic [NCH-1:0] ovf_ch_q, ovf_ch_d;
    logic           ovf_global_q, ovf_global_d;
    logic           ovf_rtc_q, ovf_rtc_d;
    state_e         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic           serial_out_q, serial_out_d;
    logic           sl_q, sl_d;
    logic           busy_q, busy_d;

    for (genvar g = 0; g < NCH; g++) begin : g_ch_sync
        sync_edge_det u_ch_sync (
            .clk   (clk),
            .reset (reset),
            .din   (ch[g]),
            .pulse (ch_pulse_s[g])
        );
    end

    sync_edge_det u_rtc_sync (
        .clk   (clk),
        .reset (reset),
        .din   (rtc),
        .pulse (rtc_pulse_s)
    );

    // Live counters, snapshot into shadows, and overflow bookkeeping
    always_comb begin
        snap_s       = rtc_pulse_s & ~busy_q;
        ovf_ch_d     = ovf_ch_q;
        ovf_global_d = snap_s ? (|ovf_ch_q) : ovf_global_q;
        ovf_rtc_d    = ovf_rtc_q | (rtc_pulse_s & busy_q);
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]    = cnt_q[i];
            shadow_d[i] = shadow_q[i];
            if (snap_s) begin
                // A pulse coinciding with the snapshot opens the new window
                shadow_d[i] = cnt_q[i];
                cnt_d[i]    = ch_pulse_s[i] ? CNT_ONE : CNT_ZERO;
                ovf_ch_d[i] = 1'b0;
            end else if (ch_pulse_s[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_ch_d[i] = 1'b1;
                    cnt_d[i]    = (SAT != 0) ? CNT_MAX : CNT_ZERO;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Readout sequencer; outputs are decoded from next state so they come out of flops
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        bit_d   = bit_q;
        case (state_q)
            ST_IDLE: begin
                if (snap_s) begin
                    state_d = ST_LOAD;
                    addr_d  = ADDR_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
                bit_d   = BIT_ZERO;
            end
            ST_SHIFT: begin
                if (bit_q == BIT_LAST) begin
                    if (addr_q == ADDR_LAST) begin
                        state_d = ST_IDLE;
                        addr_d  = ADDR_ZERO;
                    end else begin
                        state_d = ST_LOAD;
                        addr_d  = addr_q + ADDR_ONE;
                    end
                end else begin
                    bit_d = bit_q + BIT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                addr_d  = ADDR_ZERO;
                bit_d   = BIT_ZERO;
            end
        endcase
        word_s       = shadow_q[addr_d] << bit_d;
        busy_d       = (state_d != ST_IDLE);
        sl_d         = (state_d == ST_LOAD);
        serial_out_d = (state_d == ST_SHIFT) & word_s[CW-1];
    end

    // State registers; reset aborts any frame in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= CNT_ZERO;
                shadow_q[i] <= CNT_ZERO;
            end
            ovf_ch_q     <= {NCH{1'b0}};
            ovf_global_q <= 1'b0;
            ovf_rtc_q    <= 1'b0;
            state_q      <= ST_IDLE;
            addr_q       <= ADDR_ZERO;
            bit_q        <= BIT_ZERO;
            serial_out_q <= 1'b0;
            sl_q         <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            ovf_ch_q     <= ovf_ch_d;
            ovf_global_q <= ovf_global_d;
            ovf_rtc_q    <= ovf_rtc_d;
            state_q      <= state_d;
            addr_q       <= addr_d;
            bit_q        <= bit_d;
            serial_out_q <= serial_out_d;
            sl_q         <= sl_d;
            busy_q       <= busy_d;
        end
    end

    assign serial_out = serial_out_q;
    assign addr       = addr_q;
    assign sl         = sl_q;
    assign busy       = busy_q;
    assign ovf_global = ovf_global_q;
    assign ovf_rtc    = ovf_rtc_q;

endmodule
